// File: rtl/button_edge_gen_pkg.sv
// Shared definitions for the pushbutton conditioner: channel state encodings
// (also decoded by central_timing's state_debug) and a small width helper.
package button_edge_gen_pkg;

  typedef logic [1:0] btn_state_t;

  localparam btn_state_t ST_RELEASED     = 2'd0;
  localparam btn_state_t ST_PRESS_WAIT   = 2'd1;
  localparam btn_state_t ST_PRESSED      = 2'd2;
  localparam btn_state_t ST_RELEASE_WAIT = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_edge_gen_if.sv
// Board-side bundle of the button conditioner: raw pins in, strobes/levels out,
// plus per-channel FSM state for debug decoding.
interface button_edge_gen_if;
  import button_edge_gen_pkg::*;

  // btn_edge_* are valid-only pulses: high for exactly one cycle per accepted
  // event, no ready/backpressure; the consumer must sample every cycle.
  logic       btn_raw_l;
  logic       btn_raw_r;
  logic       btn_edge_l;
  logic       btn_edge_r;
  logic       btn_level_l;
  logic       btn_level_r;
  btn_state_t state_l;
  btn_state_t state_r;

  modport master (
    output btn_raw_l, btn_raw_r,
    input  btn_edge_l, btn_edge_r, btn_level_l, btn_level_r, state_l, state_r
  );

  modport slave (
    input  btn_raw_l, btn_raw_r,
    output btn_edge_l, btn_edge_r, btn_level_l, btn_level_r, state_l, state_r
  );

endinterface

// File: rtl/button_edge_gen_channel.sv
// One button: synchroniser, debounce FSM with saturating counter, and (when
// BTN_REPEAT_EN is defined and REPEAT_ON=1) a hold-to-repeat timer.
module button_edge_gen_channel
  import button_edge_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000,
  parameter int REPEAT_ON       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_i,
  output logic       strobe_o,
  output logic       level_o,
  output btn_state_t state_o
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 ||
      REPEAT_PERIOD < 1 || (REPEAT_ON != 0 && REPEAT_ON != 1)) begin : g_bad_params
    $error("button_edge_gen_channel: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sync_last;
  logic                   press_stb;
  logic                   rpt_hit;

  assign sync_d    = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_stb = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (sync_last) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_last) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_PRESSED;
          cnt_d     = '0;
          press_stb = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!sync_last) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        // A bounce back to high returns to PRESSED silently; release never strobes.
        if (sync_last) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BTN_REPEAT_EN
  if (REPEAT_ON != 0) begin : g_repeat
    localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             first_q, first_d;
    logic             hit;

    // Timer runs only while held in PRESSED; any exit re-arms the long first delay.
    always_comb begin
      rpt_d   = '0;
      first_d = 1'b1;
      hit     = 1'b0;
      if (state_q == ST_PRESSED && sync_last) begin
        hit = first_q ? (rpt_q == RPT_W'(REPEAT_DELAY - 1))
                      : (rpt_q == RPT_W'(REPEAT_PERIOD - 1));
        if (hit) begin
          rpt_d   = '0;
          first_d = 1'b0;
        end else begin
          rpt_d   = rpt_q + RPT_W'(1);
          first_d = first_q;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rpt_q   <= '0;
        first_q <= 1'b1;
      end else begin
        rpt_q   <= rpt_d;
        first_q <= first_d;
      end
    end

    assign rpt_hit = hit;
  end else begin : g_no_repeat
    assign rpt_hit = 1'b0;
  end
`else
  assign rpt_hit = 1'b0;
`endif

  assign strobe_o = press_stb | rpt_hit;
  assign level_o  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
  assign state_o  = state_q;

endmodule

// File: rtl/button_edge_gen.sv
// Calculator pushbutton conditioner: two debounce channels, clear-over-step
// strobe priority and registered strobes. BTN_REPEAT_EN enables right-button repeat.
module button_edge_gen
  import button_edge_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input logic               clk,
  input logic               reset,
  button_edge_gen_if.slave  bus
);

  logic strobe_l;
  logic strobe_r;
  logic edge_l_q, edge_l_d;
  logic edge_r_q, edge_r_d;

  button_edge_gen_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_ON       (0)
  ) u_left (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (bus.btn_raw_l),
    .strobe_o (strobe_l),
    .level_o  (bus.btn_level_l),
    .state_o  (bus.state_l)
  );

  button_edge_gen_channel #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REPEAT_ON       (1)
  ) u_right (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (bus.btn_raw_r),
    .strobe_o (strobe_r),
    .level_o  (bus.btn_level_r),
    .state_o  (bus.state_r)
  );

  // Clear wins: a coincident step strobe is dropped, not deferred.
  assign edge_l_d = strobe_l;
  assign edge_r_d = strobe_r & ~strobe_l;

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_l_q <= 1'b0;
      edge_r_q <= 1'b0;
    end else begin
      edge_l_q <= edge_l_d;
      edge_r_q <= edge_r_d;
    end
  end

  assign bus.btn_edge_l = edge_l_q;
  assign bus.btn_edge_r = edge_r_q;

endmodule

// File: tb/tb_button_edge_gen.sv
// Directed bench for button_edge_gen; strobe events go through an expected
// queue popped by a monitor, levels and states are checked inline.
module tb_button_edge_gen;
  import button_edge_gen_pkg::*;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int REPEAT_DELAY    = 8;
  localparam int REPEAT_PERIOD   = 3;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int W               = 32;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] exp_q[$];

  button_edge_gen_if bus ();

  button_edge_gen #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event encoding: {channel (0=left,1=right), cycle index of the strobe}
  function automatic logic [W-1:0] ev(input logic ch, input int c);
    logic [31:0] cv;
    cv = c;
    return {ch, cv[30:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic drive(input logic l, input logic r);
    bus.btn_raw_l = l;
    bus.btn_raw_r = r;
  endtask

  task automatic drain(input string name);
    step(12);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int e0;
    reset = 1'b1;
    drive(1'b0, 1'b0);
    fork
      begin : stim
        // reset state, with right button already held
        drive(1'b0, 1'b1);
        step(3);
        check("rst_edge_l", bus.btn_edge_l, 0);
        check("rst_edge_r", bus.btn_edge_r, 0);
        check("rst_level_l", bus.btn_level_l, 0);
        check("rst_level_r", bus.btn_level_r, 0);
        check("rst_state_r", bus.state_r, ST_RELEASED);
        reset = 1'b0;
        e0 = cyc + 1;
        exp_q.push_back(ev(1'b1, e0 + LAT));
        wait_to(e0 + LAT - 1);
        check("held_rst_level_pre", bus.btn_level_r, 0);
        step(1);
        check("held_rst_level", bus.btn_level_r, 1);
        drive(1'b0, 1'b0);
        drain("held_rst_drain");
        check("held_rst_level_rel", bus.btn_level_r, 0);

        // clean right press
        e0 = cyc + 1;
        drive(1'b0, 1'b1);
        exp_q.push_back(ev(1'b1, e0 + 6));
        wait_to(e0 + 5);
        check("clean_level_pre", bus.btn_level_r, 0);
        step(1);
        check("clean_level", bus.btn_level_r, 1);
        check("clean_state", bus.state_r, ST_PRESSED);
        step(4);
        drive(1'b0, 1'b0);
        drain("clean_drain");

        // glitch: three high samples only
        e0 = cyc + 1;
        drive(1'b0, 1'b1);
        step(3);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
          step(1);
          check("glitch_level", bus.btn_level_r, 0);
        end
        drain("glitch_drain");

        // bounce on release
        e0 = cyc + 1;
        drive(1'b0, 1'b1);
        exp_q.push_back(ev(1'b1, e0 + 6));
        step(10);
        drive(1'b0, 1'b0);
        step(1);
        drive(1'b0, 1'b1);
        step(1);
        drive(1'b0, 1'b0);
        for (int c = 13; c <= 17; c++) begin
          wait_to(e0 + c);
          check("bounce_level_hold", bus.btn_level_r, 1);
        end
        step(1);
        check("bounce_level_rel", bus.btn_level_r, 0);
        drain("bounce_drain");

        // simultaneous rise: left wins
        e0 = cyc + 1;
        drive(1'b1, 1'b1);
        exp_q.push_back(ev(1'b0, e0 + 6));
        wait_to(e0 + 6);
        check("simul_level_l", bus.btn_level_l, 1);
        check("simul_level_r", bus.btn_level_r, 1);
        step(4);
        drive(1'b0, 1'b0);
        drain("simul_drain");

        // reset mid-debounce
        e0 = cyc + 1;
        drive(1'b1, 1'b0);
        exp_q.push_back(ev(1'b0, e0 + 10));
        wait_to(e0 + 2);
        check("middeb_state_pre", bus.state_l, ST_PRESS_WAIT);
        reset = 1'b1;
        step(1);
        check("middeb_state_rst", bus.state_l, ST_RELEASED);
        check("middeb_level_rst", bus.btn_level_l, 0);
        reset = 1'b0;
        wait_to(e0 + 10);
        check("middeb_level", bus.btn_level_l, 1);
        step(3);
        drive(1'b0, 1'b0);
        drain("middeb_drain");

        // long hold on the right button
        e0 = cyc + 1;
        drive(1'b0, 1'b1);
        exp_q.push_back(ev(1'b1, e0 + 6));
`ifdef BTN_REPEAT_EN
        exp_q.push_back(ev(1'b1, e0 + 14));
        for (int c = 17; c <= 29; c += 3) exp_q.push_back(ev(1'b1, c + e0));
`endif
        wait_to(e0 + 29);
        drive(1'b0, 1'b0);
        step(6);
        drain("hold_drain");
        check("hold_level_rel", bus.btn_level_r, 0);
      end
      begin : monitor
        forever begin
          @(negedge clk);
          if (bus.btn_edge_l && bus.btn_edge_r)
            check("strobe_exclusive", {bus.btn_edge_l, bus.btn_edge_r}, 2'b10);
          if (bus.btn_edge_l || bus.btn_edge_r) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_strobe: got l=%0b r=%0b at cycle %0d, required none",
                       bus.btn_edge_l, bus.btn_edge_r, cyc);
            end else begin
              check("strobe_event", ev(bus.btn_edge_r, cyc), exp_q.pop_front());
            end
          end
        end
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
